// File: rtl/occupancy_counter.sv
// Parametrised push/pop occupancy counter with full/empty and almost flags,
// sticky overflow/underflow errors, a high-watermark register and saturate/wrap modes.
module occupancy_counter #(
  parameter int DEPTH    = 3,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter bit SATURATE = 1'b1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          err_clr,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow,
  output logic [CW-1:0] peak,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   peak_q, peak_d;
  logic            ov_q, ov_d;
  logic            un_q, un_d;
  logic            ae_q, ae_d;
  logic            af_q, af_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      peak_q  <= '0;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      peak_q  <= peak_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
    end
  end

  // Error clear is applied first so that a same-edge error event overrides it.
  always_comb begin
    count_d = count_q;
    peak_d  = peak_q;
    ov_d    = ov_q;
    un_d    = un_q;
    if (err_clr) begin
      ov_d = 1'b0;
      un_d = 1'b0;
    end
    if (clr) begin
      count_d = '0;
      peak_d  = '0;
    end else if (push && pop) begin
      count_d = count_q;
    end else if (push) begin
      if (state_q == S_FULL) begin
        ov_d    = 1'b1;
        count_d = SATURATE ? DEPTH_C : '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (state_q == S_EMPTY) begin
        un_d    = 1'b1;
        count_d = SATURATE ? '0 : DEPTH_C;
      end else begin
        count_d = count_q - CW'(1);
      end
    end
    if (!clr && (count_d > peak_q)) begin
      peak_d = count_d;
    end
  end

  // State and almost flags follow the next count so they register with it.
  always_comb begin
    state_d = S_PARTIAL;
    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == DEPTH_C) begin
      state_d = S_FULL;
    end
    ae_d = (count_d <= AE_C);
    af_d = (count_d >= AF_C);
  end

  assign count        = count_q;
  assign peak         = peak_q;
  assign empty        = (state_q == S_EMPTY);
  assign full         = (state_q == S_FULL);
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ov_q;
  assign underflow    = un_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed bench for occupancy_counter: DEPTH=3 saturating (a), DEPTH=3 wrapping (b),
// and DEPTH=5 wrapping (c); expected outputs go into queues checked by a monitor.
module tb_occupancy_counter;
  localparam int W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr_ab, ec_ab, push_ab, pop_ab;
  logic clr_c, ec_c, push_c, pop_c;

  logic [1:0] cnt_a, pk_a, st_a, cnt_b, pk_b, st_b;
  logic [2:0] cnt_c, pk_c;
  logic [1:0] st_c;
  logic em_a, fu_a, ae_a, af_a, ov_a, un_a;
  logic em_b, fu_b, ae_b, af_b, ov_b, un_b;
  logic em_c, fu_c, ae_c, af_c, ov_c, un_c;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] exp_c[$];
  int checks = 0;
  int errors = 0;

  occupancy_counter #(.DEPTH(3), .SATURATE(1'b1)) u_a (
    .clk(clk), .rst(rst), .clr(clr_ab), .err_clr(ec_ab), .push(push_ab), .pop(pop_ab),
    .count(cnt_a), .empty(em_a), .full(fu_a), .almost_empty(ae_a), .almost_full(af_a),
    .overflow(ov_a), .underflow(un_a), .peak(pk_a), .dbg_state(st_a)
  );

  occupancy_counter #(.DEPTH(3), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(rst), .clr(clr_ab), .err_clr(ec_ab), .push(push_ab), .pop(pop_ab),
    .count(cnt_b), .empty(em_b), .full(fu_b), .almost_empty(ae_b), .almost_full(af_b),
    .overflow(ov_b), .underflow(un_b), .peak(pk_b), .dbg_state(st_b)
  );

  occupancy_counter #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .SATURATE(1'b0)) u_c (
    .clk(clk), .rst(rst), .clr(clr_c), .err_clr(ec_c), .push(push_c), .pop(pop_c),
    .count(cnt_c), .empty(em_c), .full(fu_c), .almost_empty(ae_c), .almost_full(af_c),
    .overflow(ov_c), .underflow(un_c), .peak(pk_c), .dbg_state(st_c)
  );

  // Layout: {state[1:0], count[2:0], peak[2:0], empty, full, ae, af, ov, un}
  logic [W-1:0] act_a, act_b, act_c;
  assign act_a = {st_a, 1'b0, cnt_a, 1'b0, pk_a, em_a, fu_a, ae_a, af_a, ov_a, un_a};
  assign act_b = {st_b, 1'b0, cnt_b, 1'b0, pk_b, em_b, fu_b, ae_b, af_b, ov_b, un_b};
  assign act_c = {st_c, cnt_c, pk_c, em_c, fu_c, ae_c, af_c, ov_c, un_c};

  function automatic logic [W-1:0] model(input int depth, input int af, input int ae,
                                         input int cnt, input int pk, input int ov, input int un);
    logic [1:0] st;
    logic [2:0] c3, p3;
    st = (cnt == 0) ? 2'd0 : (cnt == depth) ? 2'd2 : 2'd1;
    c3 = 3'(cnt);
    p3 = 3'(pk);
    return {st, c3, p3, (cnt == 0), (cnt == depth), (cnt <= ae), (cnt >= af), (ov != 0), (un != 0)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (st|cnt|peak|em fu ae af ov un)", name, act, exp);
    end
  endtask

  // Monitor: outputs are stable 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_a.size() > 0) check("dut_a", act_a, exp_a.pop_front());
    if (exp_b.size() > 0) check("dut_b", act_b, exp_b.pop_front());
    if (exp_c.size() > 0) check("dut_c", act_c, exp_c.pop_front());
  end

  task automatic step_ab(input logic c, input logic e, input logic pu, input logic po,
                         input int ca, input int pa, input int oa, input int ua,
                         input int cb, input int pb, input int ob, input int ub);
    @(negedge clk);
    clr_ab = c; ec_ab = e; push_ab = pu; pop_ab = po;
    exp_a.push_back(model(3, 2, 1, ca, pa, oa, ua));
    exp_b.push_back(model(3, 2, 1, cb, pb, ob, ub));
  endtask

  task automatic step_c(input logic pu, input logic po, input int cc, input int pc,
                        input int oc, input int uc);
    @(negedge clk);
    clr_c = 1'b0; ec_c = 1'b0; push_c = pu; pop_c = po;
    exp_c.push_back(model(5, 4, 1, cc, pc, oc, uc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clr_ab = 0; ec_ab = 0; push_ab = 0; pop_ab = 0;
    clr_c = 0; ec_c = 0; push_c = 0; pop_c = 0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_a", act_a, model(3, 2, 1, 0, 0, 0, 0));
    check("reset_b", act_b, model(3, 2, 1, 0, 0, 0, 0));
    check("reset_c", act_c, model(5, 4, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    // Fill, overflow, error clear
    step_ab(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0);
    step_ab(0, 0, 1, 0, 2, 2, 0, 0, 2, 2, 0, 0);
    step_ab(0, 0, 1, 0, 3, 3, 0, 0, 3, 3, 0, 0);
    step_ab(0, 0, 1, 0, 3, 3, 1, 0, 0, 3, 1, 0);
    step_ab(0, 0, 0, 0, 3, 3, 1, 0, 0, 3, 1, 0);
    step_ab(0, 1, 0, 0, 3, 3, 0, 0, 0, 3, 0, 0);
    // Underflow
    step_ab(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_ab(0, 0, 0, 1, 0, 0, 0, 1, 3, 3, 0, 1);
    step_ab(0, 0, 1, 1, 0, 0, 0, 1, 3, 3, 0, 1);
    step_ab(0, 1, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
    // Simultaneous push and pop at 2 and 3, then err_clr racing an overflow
    step_ab(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step_ab(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0);
    step_ab(0, 0, 1, 0, 2, 2, 0, 0, 2, 2, 0, 0);
    step_ab(0, 0, 1, 1, 2, 2, 0, 0, 2, 2, 0, 0);
    step_ab(0, 0, 1, 0, 3, 3, 0, 0, 3, 3, 0, 0);
    step_ab(0, 0, 1, 1, 3, 3, 0, 0, 3, 3, 0, 0);
    step_ab(0, 1, 1, 0, 3, 3, 1, 0, 0, 3, 1, 0);
    // Clear beats push and keeps the sticky errors
    step_ab(0, 0, 0, 1, 2, 3, 1, 0, 3, 3, 1, 1);
    step_ab(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    step_ab(0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1);
    step_ab(0, 0, 1, 0, 2, 2, 1, 0, 2, 2, 1, 1);

    // Asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_a", act_a, model(3, 2, 1, 0, 0, 0, 0));
    check("async_reset_b", act_b, model(3, 2, 1, 0, 0, 0, 0));
    @(negedge clk);
    clr_ab = 0; ec_ab = 0; push_ab = 0; pop_ab = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // DEPTH=5 wrap modulo 6
    step_c(1, 0, 1, 1, 0, 0);
    step_c(1, 0, 2, 2, 0, 0);
    step_c(1, 0, 3, 3, 0, 0);
    step_c(1, 0, 4, 4, 0, 0);
    step_c(1, 0, 5, 5, 0, 0);
    step_c(1, 0, 0, 5, 1, 0);
    step_c(0, 1, 5, 5, 1, 1);
    step_c(0, 0, 5, 5, 1, 1);

    @(negedge clk);
    push_c = 0; pop_c = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, wanted 0",
               exp_a.size() + exp_b.size() + exp_c.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
